horner_stream_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that lets two AXI-Stream producers share one `process` core's 64-bit slave input.
- Owner is locked from first beat to tlast, so packets are never interleaved.
- Tags each outgoing packet with its source ID and keeps per-source packet counters.
- Guards the core against runaway packets: any packet longer than MAX_BEATS is truncated and the rest is drained.

---
 rtl/horner_stream_arbiter.sv | 164 ++++++++++++++++
 tb/tb_horner_stream_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_stream_arbiter.sv
// -----------------------------------------------------------------------------
// horner_stream_arbiter
//
// Packet-granular round-robin arbiter that lets two AXI-Stream producers share
// one 64-bit slave input. Ownership is locked from the first beat to tlast, so
// packets never interleave. Each outgoing beat carries its source ID. The block
// also keeps per-source packet counters and cuts off runaway packets at
// MAX_BEATS: the forwarded part gets a forced tlast, and the rest is drained.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   s0_* / s1_*              producer streams (tdata, tvalid, tlast, tready)
//   m_*                      stream to the core (tdata, tvalid, tlast, tready)
//   m_tid                    current owner; meaningful while m_tvalid
//   busy                     high while a packet is granted or being drained
//   pkt_cnt0 / pkt_cnt1      completed packets per source, wrapping
//   err_overlen / err_clr    sticky overlength flag and its clear
// -----------------------------------------------------------------------------
module horner_stream_arbiter #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MAX_BEATS  = 256,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s0_tdata,
   input  logic                  s0_tvalid,
   input  logic                  s0_tlast,
   output logic                  s0_tready,
   input  logic [DATA_WIDTH-1:0] s1_tdata,
   input  logic                  s1_tvalid,
   input  logic                  s1_tlast,
   output logic                  s1_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic                  m_tid,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pkt_cnt0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt1,
   output logic                  err_overlen,
   input  logic                  err_clr
);

   localparam int unsigned       BEAT_W    = $clog2(MAX_BEATS);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]           r_state;
   logic                 r_owner;
   logic                 r_ptr;
   logic [BEAT_W-1:0]    r_beat_cnt;
   logic [CNT_WIDTH-1:0] r_pkt_cnt0;
   logic [CNT_WIDTH-1:0] r_pkt_cnt1;
   logic                 r_err;

   logic [DATA_WIDTH-1:0] w_own_tdata;
   logic                  w_own_tvalid;
   logic                  w_own_tlast;
   logic                  w_at_limit;
   logic                  w_hs;
   logic                  w_overlen;

   assign w_own_tdata  = r_owner ? s1_tdata  : s0_tdata;
   assign w_own_tvalid = r_owner ? s1_tvalid : s0_tvalid;
   assign w_own_tlast  = r_owner ? s1_tlast  : s0_tlast;
   assign w_at_limit   = (r_beat_cnt == BEAT_LAST);
   assign w_hs         = (r_state == ST_GRANT) & w_own_tvalid & m_tready;
   // A real tlast on the limit beat is a normal completion, not an error.
   assign w_overlen    = w_hs & ~w_own_tlast & w_at_limit;

   assign pkt_cnt0    = r_pkt_cnt0;
   assign pkt_cnt1    = r_pkt_cnt1;
   assign err_overlen = r_err;

   // Handshake outputs are gated by aresetn so they read as idle while reset is held.
   always_comb begin
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      m_tdata   = w_own_tdata;
      m_tid     = r_owner & aresetn;
      busy      = aresetn & (r_state != ST_IDLE);
      if (aresetn) begin
         case (r_state)
            ST_GRANT: begin
               m_tvalid  = w_own_tvalid;
               m_tlast   = w_own_tlast | w_at_limit;
               s0_tready = ~r_owner & m_tready;
               s1_tready = r_owner & m_tready;
            end
            ST_DRAIN: begin
               // Swallow the remainder of a truncated packet.
               s0_tready = ~r_owner;
               s1_tready = r_owner;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= ST_IDLE;
         r_owner    <= 1'b0;
         r_ptr      <= 1'b0;
         r_beat_cnt <= '0;
         r_pkt_cnt0 <= '0;
         r_pkt_cnt1 <= '0;
         r_err      <= 1'b0;
      end else begin
         // Set has priority over clear.
         if (w_overlen) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (s0_tvalid | s1_tvalid) begin
                  r_owner <= (s0_tvalid & s1_tvalid) ? r_ptr : s1_tvalid;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_hs) begin
                  if (w_own_tlast || w_at_limit) begin
                     if (r_owner) begin
                        r_pkt_cnt1 <= r_pkt_cnt1 + CNT_WIDTH'(1);
                     end else begin
                        r_pkt_cnt0 <= r_pkt_cnt0 + CNT_WIDTH'(1);
                     end
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                  end
                  if (w_own_tlast) begin
                     r_ptr   <= ~r_owner;
                     r_state <= ST_IDLE;
                  end else if (w_at_limit) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_own_tvalid && w_own_tlast) begin
                  r_ptr   <= ~r_owner;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_horner_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_horner_stream_arbiter
//
// Directed vector table, hand-written contention and reset sequences, then
// randomized traffic checked against a packet-level reference model.
// -----------------------------------------------------------------------------
module tb_horner_stream_arbiter;

   localparam int DW = 64;
   localparam int MB = 4;
   localparam int CW = 16;

   logic          aclk;
   logic          aresetn;
   logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic          s0_tvalid, s0_tlast, s0_tready;
   logic          s1_tvalid, s1_tlast, s1_tready;
   logic          m_tvalid, m_tlast, m_tready, m_tid, busy;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;
   logic          err_overlen, err_clr;

   horner_stream_arbiter #(
      .DATA_WIDTH(DW),
      .MAX_BEATS (MB),
      .CNT_WIDTH (CW)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .s0_tdata   (s0_tdata),
      .s0_tvalid  (s0_tvalid),
      .s0_tlast   (s0_tlast),
      .s0_tready  (s0_tready),
      .s1_tdata   (s1_tdata),
      .s1_tvalid  (s1_tvalid),
      .s1_tlast   (s1_tlast),
      .s1_tready  (s1_tready),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready),
      .m_tid      (m_tid),
      .busy       (busy),
      .pkt_cnt0   (pkt_cnt0),
      .pkt_cnt1   (pkt_cnt1),
      .err_overlen(err_overlen),
      .err_clr    (err_clr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          rstn;
      logic          s0v, s0l;
      logic [DW-1:0] s0d;
      logic          s1v, s1l;
      logic [DW-1:0] s1d;
      logic          mr, clr;
      logic          e_s0r, e_s1r, e_mv, e_ml, e_mid;
      logic [DW-1:0] e_md;
      logic          e_busy;
      logic [CW-1:0] e_c0, e_c1;
      logic          e_err;
   } vec_t;

   function automatic vec_t mk(
      input logic rstn, input logic s0v, input logic s0l, input logic [DW-1:0] s0d,
      input logic s1v, input logic s1l, input logic [DW-1:0] s1d,
      input logic mr, input logic clr,
      input logic e_s0r, input logic e_s1r, input logic e_mv, input logic e_ml,
      input logic e_mid, input logic [DW-1:0] e_md, input logic e_busy,
      input logic [CW-1:0] e_c0, input logic [CW-1:0] e_c1, input logic e_err);
      vec_t v;
      v.rstn = rstn; v.s0v = s0v; v.s0l = s0l; v.s0d = s0d;
      v.s1v = s1v; v.s1l = s1l; v.s1d = s1d; v.mr = mr; v.clr = clr;
      v.e_s0r = e_s0r; v.e_s1r = e_s1r; v.e_mv = e_mv; v.e_ml = e_ml;
      v.e_mid = e_mid; v.e_md = e_md; v.e_busy = e_busy;
      v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_err = e_err;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      aresetn   = v.rstn;
      s0_tvalid = v.s0v; s0_tlast = v.s0l; s0_tdata = v.s0d;
      s1_tvalid = v.s1v; s1_tlast = v.s1l; s1_tdata = v.s1d;
      m_tready  = v.mr;  err_clr  = v.clr;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, " s0_tready"}, s0_tready, v.e_s0r);
      chk({tag, " s1_tready"}, s1_tready, v.e_s1r);
      chk({tag, " m_tvalid"}, m_tvalid, v.e_mv);
      chk({tag, " busy"}, busy, v.e_busy);
      chk({tag, " pkt_cnt0"}, pkt_cnt0, v.e_c0);
      chk({tag, " pkt_cnt1"}, pkt_cnt1, v.e_c1);
      chk({tag, " err_overlen"}, err_overlen, v.e_err);
      if (v.e_mv) begin
         chk({tag, " m_tdata"}, m_tdata, v.e_md);
         chk({tag, " m_tlast"}, m_tlast, v.e_ml);
         chk({tag, " m_tid"}, m_tid, v.e_mid);
      end
   endtask

   // Reference model state for the random phase.
   int            md;   // 0 waiting for arbitration, 1 forwarding, 2 discarding
   int            own, ptr, sent;
   logic [CW-1:0] c0, c1;
   logic          err;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[$];
      vec_t v;
      vec_t e;
      logic [DW-1:0] want;
      int s0_beat, s1_beat, s0_pkt, s1_pkt, seen, lasts, src, bt, pk;
      logic ov, ol, set_err;

      drive(mk(0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0,0,0,0));
      repeat (2) @(posedge aclk);

      // rstn s0v s0l s0d  s1v s1l s1d  mr clr | s0r s1r mv ml mid md busy c0 c1 err
      // Reset held with s0 pending: handshake outputs stay idle.
      tv.push_back(mk(0, 1,0,'h1, 0,0,0, 1,0,  0,0,0,0,0,0, 0, 0,0,0));
      // Single-source 4-beat packet; tlast coincides with the beat limit.
      tv.push_back(mk(1, 1,0,'h1, 0,0,0, 1,0,  0,0,0,0,0,0, 0, 0,0,0));
      tv.push_back(mk(1, 1,0,'h1, 0,0,0, 1,0,  1,0,1,0,0,'h1, 1, 0,0,0));
      tv.push_back(mk(1, 1,0,'h2, 0,0,0, 1,0,  1,0,1,0,0,'h2, 1, 0,0,0));
      tv.push_back(mk(1, 1,0,'h3, 0,0,0, 1,0,  1,0,1,0,0,'h3, 1, 0,0,0));
      tv.push_back(mk(1, 1,1,'h4, 0,0,0, 1,0,  1,0,1,1,0,'h4, 1, 0,0,0));
      tv.push_back(mk(1, 0,0,0,   0,0,0, 1,0,  0,0,0,0,0,0, 0, 1,0,0));
      // Backpressure: s1 3-beat packet, m_tready 1,0,1,0,1.
      tv.push_back(mk(1, 0,0,0, 1,0,'hA, 1,0,  0,0,0,0,0,0, 0, 1,0,0));
      tv.push_back(mk(1, 0,0,0, 1,0,'hA, 1,0,  0,1,1,0,1,'hA, 1, 1,0,0));
      tv.push_back(mk(1, 0,0,0, 1,0,'hB, 0,0,  0,0,1,0,1,'hB, 1, 1,0,0));
      tv.push_back(mk(1, 0,0,0, 1,0,'hB, 1,0,  0,1,1,0,1,'hB, 1, 1,0,0));
      tv.push_back(mk(1, 0,0,0, 1,1,'hC, 0,0,  0,0,1,1,1,'hC, 1, 1,0,0));
      tv.push_back(mk(1, 0,0,0, 1,1,'hC, 1,0,  0,1,1,1,1,'hC, 1, 1,0,0));
      tv.push_back(mk(1, 0,0,0, 0,0,0,   1,0,  0,0,0,0,0,0, 0, 1,1,0));
      // Overlength: s0 sends 7 beats while s1 waits.
      tv.push_back(mk(1, 1,0,'h10, 1,0,'h20, 1,0,  0,0,0,0,0,0, 0, 1,1,0));
      tv.push_back(mk(1, 1,0,'h10, 1,0,'h20, 1,0,  1,0,1,0,0,'h10, 1, 1,1,0));
      tv.push_back(mk(1, 1,0,'h11, 1,0,'h20, 1,0,  1,0,1,0,0,'h11, 1, 1,1,0));
      tv.push_back(mk(1, 1,0,'h12, 1,0,'h20, 1,0,  1,0,1,0,0,'h12, 1, 1,1,0));
      tv.push_back(mk(1, 1,0,'h13, 1,0,'h20, 1,0,  1,0,1,1,0,'h13, 1, 1,1,0));
      tv.push_back(mk(1, 1,0,'h14, 1,0,'h20, 1,0,  1,0,0,0,0,0, 1, 2,1,1));
      tv.push_back(mk(1, 1,0,'h15, 1,0,'h20, 1,0,  1,0,0,0,0,0, 1, 2,1,1));
      tv.push_back(mk(1, 1,1,'h16, 1,0,'h20, 1,0,  1,0,0,0,0,0, 1, 2,1,1));
      // s1 wins next even though s0 is pending again; err_clr pulses.
      tv.push_back(mk(1, 1,0,'h30, 1,0,'h20, 1,0,  0,0,0,0,0,0, 0, 2,1,1));
      tv.push_back(mk(1, 1,0,'h30, 1,1,'h20, 1,1,  0,1,1,1,1,'h20, 1, 2,1,1));
      tv.push_back(mk(1, 0,0,0,    0,0,0,    1,0,  0,0,0,0,0,0, 0, 2,2,0));

      foreach (tv[i]) begin
         @(posedge aclk); #1;
         drive(tv[i]);
         #3;
         check_vec($sformatf("vec%0d", i), tv[i]);
      end

      // Reset in the middle of an s0 packet.
      @(posedge aclk); #1;
      drive(mk(1, 1,0,'h55, 0,0,0, 1,0,  0,0,0,0,0,0,0,0,0,0));
      @(posedge aclk); #1;
      #3;
      chk("midpkt m_tvalid", m_tvalid, 1'b1);
      @(posedge aclk); #1;
      aresetn = 1'b0;
      #3;
      chk("rst s0_tready", s0_tready, 1'b0);
      chk("rst m_tvalid", m_tvalid, 1'b0);
      chk("rst m_tlast", m_tlast, 1'b0);
      chk("rst m_tid", m_tid, 1'b0);
      chk("rst busy", busy, 1'b0);
      @(posedge aclk); #1;
      e = mk(1, 0,0,0, 0,0,0, 1,0,  0,0,0,0,0,0, 0, 0,0,0);
      drive(e);
      #3;
      check_vec("postrst", e);

      // Contention: both sources stream 2-beat packets back to back.
      s0_beat = 0; s1_beat = 0; s0_pkt = 0; s1_pkt = 0; seen = 0; lasts = 0;
      for (int cyc = 0; cyc < 40 && lasts < 4; cyc++) begin
         @(posedge aclk); #1;
         s0_tvalid = 1'b1; s0_tlast = (s0_beat == 1);
         s0_tdata  = 64'h100 + 64'(s0_pkt * 2 + s0_beat);
         s1_tvalid = 1'b1; s1_tlast = (s1_beat == 1);
         s1_tdata  = 64'h200 + 64'(s1_pkt * 2 + s1_beat);
         m_tready  = 1'b1;
         #3;
         if (m_tvalid && m_tready) begin
            src  = (seen / 2) % 2;
            bt   = seen % 2;
            pk   = seen / 4;
            want = (src == 1 ? 64'h200 : 64'h100) + 64'(pk * 2 + bt);
            chk($sformatf("cont%0d m_tid", seen), m_tid, src[0]);
            chk($sformatf("cont%0d m_tdata", seen), m_tdata, want);
            chk($sformatf("cont%0d m_tlast", seen), m_tlast, bt[0]);
            chk($sformatf("cont%0d cycle", seen), cyc, (seen / 2) * 3 + 1 + bt);
            seen++;
            if (m_tlast) lasts++;
         end
         if (s0_tready) begin
            if (s0_beat == 1) begin s0_beat = 0; s0_pkt++; end else s0_beat = 1;
         end
         if (s1_tready) begin
            if (s1_beat == 1) begin s1_beat = 0; s1_pkt++; end else s1_beat = 1;
         end
      end
      chk("cont packets done", lasts, 4);
      @(posedge aclk); #1;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      #3;
      chk("cont pkt_cnt0", pkt_cnt0, 2);
      chk("cont pkt_cnt1", pkt_cnt1, 2);

      // Random traffic against the reference model.
      @(posedge aclk); #1;
      drive(mk(0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0,0,0,0));
      @(posedge aclk); #1;
      md = 0; own = 0; ptr = 0; sent = 0; c0 = '0; c1 = '0; err = 1'b0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         @(posedge aclk); #1;
         v.rstn = ($urandom_range(0, 63) != 0);
         v.s0v  = ($urandom_range(0, 9) < 7);
         v.s0l  = ($urandom_range(0, 3) == 0);
         v.s0d  = {$urandom, $urandom};
         v.s1v  = ($urandom_range(0, 9) < 7);
         v.s1l  = ($urandom_range(0, 3) == 0);
         v.s1d  = {$urandom, $urandom};
         v.mr   = ($urandom_range(0, 9) < 7);
         v.clr  = ($urandom_range(0, 9) == 0);
         drive(v);
         ov = (own == 1) ? v.s1v : v.s0v;
         ol = (own == 1) ? v.s1l : v.s0l;
         v.e_s0r = 0; v.e_s1r = 0; v.e_mv = 0; v.e_ml = 0; v.e_mid = 0; v.e_md = '0;
         v.e_busy = v.rstn && (md != 0);
         v.e_c0 = c0; v.e_c1 = c1; v.e_err = err;
         if (v.rstn && md == 1) begin
            v.e_mv  = ov;
            v.e_ml  = ol || (sent + 1 == MB);
            v.e_mid = own[0];
            v.e_md  = (own == 1) ? v.s1d : v.s0d;
            v.e_s0r = (own == 0) && v.mr;
            v.e_s1r = (own == 1) && v.mr;
         end else if (v.rstn && md == 2) begin
            v.e_s0r = (own == 0);
            v.e_s1r = (own == 1);
         end
         #3;
         check_vec($sformatf("rnd%0d", cyc), v);
         set_err = 1'b0;
         if (!v.rstn) begin
            md = 0; own = 0; ptr = 0; sent = 0; c0 = '0; c1 = '0; err = 1'b0;
         end else begin
            if (md == 0) begin
               if (v.s0v || v.s1v) begin
                  own = (v.s0v && v.s1v) ? ptr : (v.s1v ? 1 : 0);
                  md = 1; sent = 0;
               end
            end else if (md == 1) begin
               if (ov && v.mr) begin
                  sent++;
                  if (ol || sent == MB) begin
                     if (own == 1) c1 = c1 + 1'b1; else c0 = c0 + 1'b1;
                     sent = 0;
                     if (ol) begin
                        ptr = 1 - own; md = 0;
                     end else begin
                        set_err = 1'b1; md = 2;
                     end
                  end
               end
            end else begin
               if (ov && ol) begin
                  ptr = 1 - own; md = 0;
               end
            end
            if (set_err) err = 1'b1;
            else if (v.clr) err = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
